// File: rtl/mbist_pkg.sv
// March C- MBIST shared definitions: states, op codes and the element table.
// Used by mbist_march_ctrl and mbist_resp_chk (optional MBIST_DIAG_EN).
package mbist_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    typedef struct packed {
        logic       down;
        logic [1:0] nops;
        op_t        op0;
        op_t        op1;
    } elem_t;

    function automatic logic elem_down(input logic [2:0] e);
        return (e == M3) || (e == M4) || (e == M5);
    endfunction

    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t r;
        r.down = elem_down(e);
        r.nops = 2'd2;
        r.op0  = OP_W0;
        r.op1  = OP_W0;
        case (e)
            M0: r.nops = 2'd1;
            M1: begin r.op0 = OP_R0; r.op1 = OP_W1; end
            M2: begin r.op0 = OP_R1; r.op1 = OP_W0; end
            M3: begin r.op0 = OP_R0; r.op1 = OP_W1; end
            M4: begin r.op0 = OP_R1; r.op1 = OP_W0; end
            M5: begin r.nops = 2'd1; r.op0 = OP_R0; end
            default: r.nops = 2'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mbist_resp_chk.sv
// Read-response checker: one-cycle compare pipe, sticky fail, first-fail capture.
// Saturating fail counter; syndrome capture only with MBIST_DIAG_EN.
module mbist_resp_chk
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_cnt
`ifdef MBIST_DIAG_EN
    ,
    output logic [DATA_W-1:0] fail_syndrome
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic              pend;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_exp;
    logic              miss;

    assign miss = pend && (rdata != p_exp);

    // Hold the read's address and expected word until the data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= 1'b0;
            p_addr <= '0;
            p_exp  <= '0;
        end else begin
            pend   <= rd_vld;
            p_addr <= rd_addr;
            p_exp  <= rd_exp;
        end
    end

    // Sticky fail, first failing address and saturating miss count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_cnt  <= '0;
        end else if (miss) begin
            fail <= 1'b1;
            if (!fail) fail_addr <= p_addr;
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
        end
    end

`ifdef MBIST_DIAG_EN
    // Bit-level syndrome of the first miscompare.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail_syndrome <= '0;
        end else if (miss && !fail) begin
            fail_syndrome <= rdata ^ p_exp;
        end
    end
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for one single-port SRAM: IDLE -> RUN -> DRAIN -> DONE.
// Optional MBIST_DIAG_EN adds the fail_syndrome output.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_cnt
`ifdef MBIST_DIAG_EN
    ,
    output logic [DATA_W-1:0] fail_syndrome
`endif
);

    localparam logic [ADDR_W-1:0] A_MAX = '1;
    localparam logic [ADDR_W-1:0] A_ONE = 1;

    state_t            state, state_n;
    logic [2:0]        elem, elem_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              opi, opi_n;
    elem_t             cur;
    op_t               op;
    logic              run, last_op, last_addr, nxt_down, is_rd;

    assign cur       = elem_info(elem);
    assign nxt_down  = elem_down(elem + 3'd1);
    assign op        = opi ? cur.op1 : cur.op0;
    assign run       = (state == S_RUN);
    assign is_rd     = (op == OP_R0) || (op == OP_R1);
    assign last_op   = (cur.nops == 2'd1) || opi;
    assign last_addr = cur.down ? (addr == '0) : (addr == A_MAX);

    assign mem_ce    = run;
    assign mem_we    = run && !is_rd;
    assign mem_addr  = run ? addr : '0;
    assign mem_wdata = (run && op == OP_W1) ? '1 : '0;
    assign busy      = run || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            elem  <= M0;
            addr  <= '0;
            opi   <= 1'b0;
        end else begin
            state <= state_n;
            elem  <= elem_n;
            addr  <= addr_n;
            opi   <= opi_n;
        end
    end

    // Step op -> address -> element; reload address at element boundaries.
    always_comb begin
        state_n = state;
        elem_n  = elem;
        addr_n  = addr;
        opi_n   = opi;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RUN;
                    elem_n  = M0;
                    addr_n  = '0;
                    opi_n   = 1'b0;
                end
            end
            S_RUN: begin
                if (!last_op) begin
                    opi_n = 1'b1;
                end else begin
                    opi_n = 1'b0;
                    if (!last_addr) begin
                        addr_n = cur.down ? addr - A_ONE : addr + A_ONE;
                    end else if (elem == M5) begin
                        state_n = S_DRAIN;
                    end else begin
                        elem_n = elem + 3'd1;
                        addr_n = nxt_down ? A_MAX : '0;
                    end
                end
            end
            S_DRAIN: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    mbist_resp_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clk           (clk),
        .rst           (rst),
        .clr           (start && (state == S_IDLE || state == S_DONE)),
        .rd_vld        (run && is_rd),
        .rd_addr       (addr),
        .rd_exp        ((op == OP_R1) ? {DATA_W{1'b1}} : {DATA_W{1'b0}}),
        .rdata         (mem_rdata),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_cnt      (fail_cnt)
`ifdef MBIST_DIAG_EN
        ,
        .fail_syndrome (fail_syndrome)
`endif
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl (ADDR_W=4, CNT_W=4) with a faultable SRAM model.
// Build with MBIST_DIAG_EN to also check fail_syndrome.
module tb_mbist_march_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [CW-1:0] fail_cnt;
`ifdef MBIST_DIAG_EN
    logic [DW-1:0] fail_syndrome;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_ce        (mem_ce),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_cnt      (fail_cnt)
`ifdef MBIST_DIAG_EN
        ,
        .fail_syndrome (fail_syndrome)
`endif
    );

    // SRAM model: mode 0 good, 1 stuck bit at one address, 2 constant read value.
    logic [DW-1:0] mem [N];
    int            f_mode = 0;
    int            f_addr = 0;
    int            f_bit  = 0;
    logic          f_val  = 1'b0;
    logic [DW-1:0] f_k    = '0;

    function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = d;
        if (f_mode == 1 && int'(a) == f_addr) r[f_bit] = f_val;
        else if (f_mode == 2) r = f_k;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= rd_fault(mem[mem_addr], mem_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected March C- op stream, built from the element list.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } op_s;

    op_s exp_ops[$];
    // 0=w0 1=w1 2=r0 3=r1 -1=none
    int  el_ops [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
    bit  el_up  [6]    = '{1, 1, 1, 0, 0, 0};

    task automatic build_ops();
        op_s o;
        int  a;
        exp_ops.delete();
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < N; j++) begin
                a = el_up[e] ? j : N - 1 - j;
                for (int s = 0; s < 2; s++)
                    if (el_ops[e][s] >= 0) begin
                        o.we   = (el_ops[e][s] < 2);
                        o.addr = a[AW-1:0];
                        o.wd   = (el_ops[e][s] == 1) ? '1 : '0;
                        exp_ops.push_back(o);
                    end
            end
    endtask

    typedef struct {
        string         name;
        int            mode;
        int            addr;
        int            bitn;
        logic          val;
        logic [DW-1:0] k;
        int            poke;
        logic          e_fail;
        int            e_addr;
        int            e_cnt;
        logic [DW-1:0] e_syn;
    } vec_t;

    vec_t tbl [5];

    // Expected result of a run from the fault alone (March C- read counts).
    function automatic vec_t model(input int mode, input int a, input int b,
                                   input logic v, input logic [DW-1:0] k);
        vec_t r;
        int   nf;
        r.name = "rand"; r.mode = mode; r.addr = a; r.bitn = b;
        r.val = v; r.k = k; r.poke = 0;
        if (mode == 1) begin
            // r0 reads: M1, M3, M5; r1 reads: M2, M4
            r.e_fail = 1'b1;
            r.e_addr = a;
            r.e_cnt  = v ? 3 : 2;
            r.e_syn  = '0;
            r.e_syn[b] = 1'b1;
        end else begin
            nf = (k != 0 ? 3 * N : 0) + (k != 8'hFF ? 2 * N : 0);
            r.e_fail = 1'b1;
            r.e_addr = 0;
            r.e_cnt  = nf > (1 << CW) - 1 ? (1 << CW) - 1 : nf;
            r.e_syn  = (k != 0) ? k : ~k;
        end
        return r;
    endfunction

    task automatic run_test(input vec_t v);
        op_s o;
        f_mode = v.mode; f_addr = v.addr; f_bit = v.bitn;
        f_val = v.val; f_k = v.k;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({v.name, " clr_fail"}, 32'(fail), 32'(0));
        chk({v.name, " clr_cnt"}, 32'(fail_cnt), 32'(0));
        for (int k = 1; k <= 10 * N; k++) begin
            o = exp_ops[k - 1];
            chk({v.name, " op"},
                32'({mem_ce, mem_we, mem_addr, mem_wdata, busy, done}),
                32'({1'b1, o.we, o.addr, o.wd, 1'b1, 1'b0}));
            start = (k == v.poke);
            @(negedge clk);
        end
        start = 1'b0;
        chk({v.name, " drain"}, 32'({busy, done, mem_ce}), 32'(3'b100));
        @(negedge clk);
        chk({v.name, " done"}, 32'({busy, done, mem_ce}), 32'(3'b010));
        chk({v.name, " fail"}, 32'(fail), 32'(v.e_fail));
        chk({v.name, " fail_addr"}, 32'(fail_addr), 32'(v.e_addr));
        chk({v.name, " fail_cnt"}, 32'(fail_cnt), 32'(v.e_cnt));
`ifdef MBIST_DIAG_EN
        chk({v.name, " syndrome"}, 32'(fail_syndrome), 32'(v.e_syn));
`endif
        repeat (3) @(negedge clk);
        chk({v.name, " done_held"}, 32'({busy, done, mem_ce}), 32'(3'b010));
    endtask

    initial begin
        vec_t rv;
        int   m;
        logic [DW-1:0] rk;

        tbl[0] = '{"clean",    0, 0, 0, 1'b0, 8'h00, 0,  1'b0, 0, 0,  8'h00};
        tbl[1] = '{"stuck1_a5", 1, 5, 0, 1'b1, 8'h00, 0,  1'b1, 5, 3,  8'h01};
        tbl[2] = '{"const_a5", 2, 0, 0, 1'b0, 8'hA5, 0,  1'b1, 0, 15, 8'hA5};
        tbl[3] = '{"stuck0_a9", 1, 9, 7, 1'b0, 8'h00, 0,  1'b1, 9, 2,  8'h80};
        tbl[4] = '{"poke20",   0, 0, 0, 1'b0, 8'h00, 20, 1'b0, 0, 0,  8'h00};

        build_ops();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs",
            32'({mem_ce, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr, fail_cnt}),
            32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle no strobe", 32'({mem_ce, busy, done}), 32'(0));

        for (int i = 0; i < 5; i++) run_test(tbl[i]);

        // Reset mid-run, asserted together with start: reset wins.
        f_mode = 2; f_k = 8'hA5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_rst fail", 32'(fail), 32'(1));
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("mid_rst outputs",
            32'({mem_ce, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr, fail_cnt}),
            32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst idle", 32'({mem_ce, busy, done, fail}), 32'(0));
        end
        run_test(tbl[0]);

        // Randomized single faults checked against the fault model.
        for (int i = 0; i < 6; i++) begin
            m = $urandom_range(1, 2);
            rk = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
            rv = model(m, $urandom_range(0, N - 1), $urandom_range(0, DW - 1),
                       1'($urandom_range(0, 1)), rk);
            run_test(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- MBIST sequencer and response checker for one single-port synchronous SRAM.
- Generates the March C- address/operation stream: address ascends or descends per element.
- Drives write data and checks read data one cycle later.
- Reports pass/fail, first failing address and a saturating fail count to the BIST top level.

Parameters:
- ADDR_W, 12, address width; the test covers addresses 0 .. 2^ADDR_W-1.
- DATA_W, 8, memory word width; backgrounds are all-0 and all-1.
- CNT_W, 8, width of the fail counter; the counter saturates.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE or DONE.
- mem_ce  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read; valid when mem_ce=1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid the cycle after a read strobe (latency 1).
- busy  out  1  test in progress.
- done  out  1  test complete; held until start or rst.
- fail  out  1  sticky; at least one miscompare seen.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_cnt  out  CNT_W  number of miscompares, saturating at all-ones.

Behaviour:
- Reset: every output is 0; FSM returns to IDLE. Reset takes effect in the same cycle at any point, including mid-test.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Transitions:
  - IDLE/DONE --start--> RUN. Entering RUN clears fail, fail_addr and fail_cnt.
  - RUN --last op of M5 at its last address--> DRAIN.
  - DRAIN --1 cycle--> DONE.
- March elements, executed in order (N = 2^ADDR_W):
  - M0 up: w0
  - M1 up: r0, w1
  - M2 up: r1, w0
  - M3 down: r0, w1
  - M4 down: r1, w0
  - M5 down: r0
- Up elements run address 0 to N-1; down elements run N-1 to 0. The address wraps only via an explicit reload at an element boundary, never by counter overflow.
- Each op takes exactly one cycle with mem_ce=1. There are no idle cycles between ops, addresses or elements.
- Total RUN length is 10N cycles.
- Timing: start sampled at cycle t → first op at t+1 with busy=1. DRAIN at t+10N+1. done=1 and busy=0 from t+10N+2.
- Data values: w0 drives all-0, w1 drives all-1. Ops r0 and r1 expect all-0 and all-1 respectively.
- Compare pipeline: the read's address and expected value are registered with the read. At the next cycle mem_rdata is compared against them.
- On a miscompare, the following are registered at the end of that compare cycle:
  - fail is set.
  - fail_addr is captured only if fail was 0.
  - fail_cnt is incremented unless it is all-ones.
- The compare for the last read (M5, address 0) occurs in DRAIN.
- start while busy is ignored. start and rst in the same cycle: rst wins.
- mem_ce is 0 in IDLE, DRAIN and DONE. mem_wdata is don't-care on reads and is driven 0.

Optional Feature:
- Macro: MBIST_DIAG_EN.
- With the macro: extra output fail_syndrome [DATA_W], equal to mem_rdata XOR expected, captured together with fail_addr at the first miscompare. It is reset to 0 and cleared on start.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mbist_pkg holds:
  - element encoding localparams M0..M5
  - FSM state encodings
  - the op type (W0/W1/R0/R1)
  - a per-element table: direction, op count and op list
- One sub-module, mbist_resp_chk: holds the compare pipeline register, sticky fail, first-fail capture, saturating counter and the optional syndrome.

Test Plan:
- ADDR_W=4, fault-free memory model, start pulse → 160 RUN cycles. done at t+162, fail=0, fail_cnt=0. The op/address sequence matches the March C- ordering exactly.
- ADDR_W=4, bit0 at address 5 stuck-at-1 → fail=1, fail_addr=5, fail_cnt=3 (the r0 reads in M1, M3 and M5). With MBIST_DIAG_EN, fail_syndrome=0x01.
- ADDR_W=4, CNT_W=4, memory always returns 0xA5 → all 80 reads fail. fail_cnt=15 (saturated), fail_addr=0.
- rst asserted at cycle t+50 of a run → the next cycle has all outputs 0, FSM in IDLE and no memory strobes. A new start then gives a full clean run.
- start pulsed again at t+20 while busy → ignored; done still at t+162. start in DONE → the fail state clears and a second run completes identically.
